// File: rtl/transport_arbiter.sv
// transport_arbiter
//   Shares the single transport transmit port between session call-control
//   messages and the outgoing audio stream. Control is preferred, but only
//   CTRL_BURST grants in a row while audio is waiting, so audio cannot starve.
//   Audio samples are held in a small FIFO. Every send then waits for the
//   transport to go busy and idle again, and gives up after ACK_TIMEOUT cycles.
//
// Ports
//   clk, reset        rising-edge clock, async active-high reset
//   ctrlReq/Cmd/Data  control request (level, held until ctrlAck) + payload
//   ctrlAck           one-cycle pulse when the control request is issued
//   audioValid/In     one-cycle strobe pushing one audio sample
//   transportBusy     transport is processing a send
//   sendFlag          one-cycle strobe; cmd/dataOut valid (held until next grant)
//   arbBusy           arbiter not in IDLE
//   fifoCount         audio FIFO occupancy
//   audioDrop         saturating count of samples dropped on overflow
//   timeoutFlag       one-cycle pulse when the transport never went busy
//   arbState          IDLE=0, WAIT_BUSY=1, WAIT_DONE=2
module transport_arbiter #(
   parameter int         FIFO_DEPTH  = 4,
   parameter int         CTRL_BURST  = 2,
   parameter logic [1:0] AUDIO_CMD   = 2'b11,
   parameter int         ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ctrlReq,
   input  logic [1:0]  ctrlCmd,
   input  logic [15:0] ctrlData,
   output logic        ctrlAck,
   input  logic        audioValid,
   input  logic [15:0] audioIn,
   input  logic        transportBusy,
   output logic        sendFlag,
   output logic [1:0]  cmd,
   output logic [15:0] dataOut,
   output logic        arbBusy,
   output logic [2:0]  fifoCount,
   output logic [7:0]  audioDrop,
   output logic        timeoutFlag,
   output logic [1:0]  arbState
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int RUN_W = $clog2(CTRL_BURST + 1);
   localparam int TMR_W = $clog2(ACK_TIMEOUT);

   localparam logic [2:0]       DEPTH_C   = 3'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [RUN_W-1:0] BURST_C   = RUN_W'(CTRL_BURST);
   localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } arbStateT;

   arbStateT         state, stateNext;
   logic             grantCtrl, grantAudio, timeoutHit;

   // Storage is rounded up to a power of two so the pointer indexes it
   // cleanly; pointers still wrap at FIFO_DEPTH.
   logic [15:0]      fifoMem [2**PTR_W];
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic [2:0]       count;
   logic             fifoEmpty, fifoFull;
   logic             push, pop, drop;

   logic [RUN_W-1:0] ctrlRun;
   logic [TMR_W-1:0] timer;

   assign fifoEmpty = (count == 3'd0);
   assign fifoFull  = (count == DEPTH_C);

   // Only an audio grant pops. A push into a full FIFO still lands when the
   // head leaves in the same cycle, so the slot is reused rather than dropped.
   assign pop  = grantAudio;
   assign push = audioValid && (!fifoFull || pop);
   assign drop = audioValid && fifoFull && !pop;

   assign arbState  = state;
   assign fifoCount = count;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext  = state;
      grantCtrl  = 1'b0;
      grantAudio = 1'b0;
      timeoutHit = 1'b0;
      unique case (state)
         IDLE: begin
            // Arbitration uses the registered FIFO count, so a sample pushed
            // on this edge is granted no earlier than the next one.
            if (!transportBusy) begin
               if (ctrlReq && (fifoEmpty || (ctrlRun < BURST_C)))
                  grantCtrl = 1'b1;
               else if (!fifoEmpty)
                  grantAudio = 1'b1;
               if (grantCtrl || grantAudio)
                  stateNext = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (transportBusy) begin
               stateNext = WAIT_DONE;
            end else if (timer == TMO_LAST) begin
               // Send is abandoned; nothing is re-queued.
               timeoutHit = 1'b1;
               stateNext  = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!transportBusy) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // ------------------------------------------------------- grant outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sendFlag    <= 1'b0;
         ctrlAck     <= 1'b0;
         timeoutFlag <= 1'b0;
         arbBusy     <= 1'b0;
         cmd         <= 2'd0;
         dataOut     <= 16'd0;
         ctrlRun     <= '0;
         timer       <= '0;
      end else begin
         sendFlag    <= grantCtrl | grantAudio;
         ctrlAck     <= grantCtrl;
         timeoutFlag <= timeoutHit;
         arbBusy     <= (stateNext != IDLE);

         if (grantCtrl) begin
            cmd     <= ctrlCmd;
            dataOut <= ctrlData;
            // The run only matters while audio waits; with an empty FIFO the
            // next audio sample starts a fresh burst budget.
            if (fifoEmpty)               ctrlRun <= '0;
            else if (ctrlRun != BURST_C) ctrlRun <= ctrlRun + 1'b1;
         end else if (grantAudio) begin
            cmd     <= AUDIO_CMD;
            dataOut <= fifoMem[rdPtr];
            ctrlRun <= '0;
         end

         if (grantCtrl || grantAudio)
            timer <= '0;
         else if (stateNext == WAIT_BUSY)
            timer <= timer + 1'b1;
      end
   end

   // ---------------------------------------------------------- audio FIFO
   always_ff @(posedge clk) begin
      if (push) fifoMem[wrPtr] <= audioIn;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         count     <= 3'd0;
         audioDrop <= 8'd0;
      end else begin
         if (push) wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
         if (pop)  rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;

         unique case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase

         if (drop && (audioDrop != 8'hFF)) audioDrop <= audioDrop + 8'd1;
      end
   end

endmodule

// File: tb/tb_transport_arbiter.sv
// Directed bench for transport_arbiter. Expected sends are queued when the
// stimulus is driven and matched in order by a monitor on every sendFlag.
module tb_transport_arbiter;

   logic        clk, reset;
   logic        ctrlReq;
   logic [1:0]  ctrlCmd;
   logic [15:0] ctrlData;
   logic        ctrlAck;
   logic        audioValid;
   logic [15:0] audioIn;
   logic        transportBusy;
   logic        sendFlag;
   logic [1:0]  cmd;
   logic [15:0] dataOut;
   logic        arbBusy;
   logic [2:0]  fifoCount;
   logic [7:0]  audioDrop;
   logic        timeoutFlag;
   logic [1:0]  arbState;

   typedef struct packed {
      logic        isCtrl;
      logic [1:0]  cmd;
      logic [15:0] data;
   } sendT;

   sendT q[$];
   int   checks = 0;
   int   errors = 0;
   int   sendCnt = 0;

   logic forceBusy = 1'b0;
   logic respBusy  = 1'b0;
   logic autoResp  = 1'b0;
   int   respLen   = 1;
   int   expDrop   = 0;

   assign transportBusy = forceBusy | respBusy;

   transport_arbiter dut (
      .clk(clk), .reset(reset),
      .ctrlReq(ctrlReq), .ctrlCmd(ctrlCmd), .ctrlData(ctrlData), .ctrlAck(ctrlAck),
      .audioValid(audioValid), .audioIn(audioIn), .transportBusy(transportBusy),
      .sendFlag(sendFlag), .cmd(cmd), .dataOut(dataOut), .arbBusy(arbBusy),
      .fifoCount(fifoCount), .audioDrop(audioDrop), .timeoutFlag(timeoutFlag),
      .arbState(arbState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] s);
      audioValid = 1'b1;
      audioIn    = s;
      tick(1);
      audioValid = 1'b0;
   endtask

   task automatic expAudio(input logic [15:0] s);
      q.push_back('{isCtrl: 1'b0, cmd: 2'b11, data: s});
   endtask

   task automatic expCtrl(input logic [1:0] c, input logic [15:0] d);
      q.push_back('{isCtrl: 1'b1, cmd: c, data: d});
   endtask

   task automatic waitDrain(input string tag);
      for (int i = 0; i < 400 && q.size() != 0; i++) tick(1);
      chk(tag, 32'(q.size()), 32'd0);
   endtask

   task automatic waitIdle(input string tag);
      for (int i = 0; i < 100 && (arbState != 2'd0 || transportBusy); i++) tick(1);
      chk(tag, 32'(arbState), 32'd0);
   endtask

   // Transport model: goes busy the half-cycle after a send, for respLen cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (autoResp && sendFlag) begin
            respBusy = 1'b1;
            repeat (respLen) @(negedge clk);
            respBusy = 1'b0;
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      sendT e;
      forever begin
         @(negedge clk);
         if (sendFlag && !reset) begin
            sendCnt++;
            chk("send_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("send_payload", 32'({ctrlAck, cmd, dataOut}), 32'(e));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired observed running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int target;
      logic sawTmo;

      reset = 1'b1; ctrlReq = 1'b0; ctrlCmd = 2'd0; ctrlData = 16'd0;
      audioValid = 1'b0; audioIn = 16'd0;

      // ---- reset state
      tick(2);
      chk("rst_send", 32'({sendFlag, ctrlAck, cmd, dataOut}), 32'd0);
      chk("rst_stat", 32'({arbBusy, fifoCount, audioDrop, timeoutFlag, arbState}), 32'd0);
      reset = 1'b0;

      // ---- single control send, busy held three cycles by the bench
      ctrlReq = 1'b1; ctrlCmd = 2'b01; ctrlData = 16'h3001;
      expCtrl(2'b01, 16'h3001);
      tick(1);
      chk("ctl_flags", 32'({sendFlag, ctrlAck}), 32'b11);
      chk("ctl_state1", 32'(arbState), 32'd1);
      chk("ctl_busy", 32'(arbBusy), 32'd1);
      ctrlReq = 1'b0;
      tick(1);
      chk("ctl_pulse", 32'({sendFlag, ctrlAck}), 32'b00);
      chk("ctl_still1", 32'(arbState), 32'd1);
      forceBusy = 1'b1;
      tick(1);
      chk("ctl_state2", 32'(arbState), 32'd2);
      tick(2);
      chk("ctl_hold2", 32'(arbState), 32'd2);
      forceBusy = 1'b0;
      tick(1);
      chk("ctl_state0", 32'({arbBusy, arbState}), 32'd0);
      chk("ctl_held", 32'({cmd, dataOut}), 32'({2'b01, 16'h3001}));

      // ---- starvation bound
      forceBusy = 1'b1;
      push(16'hA001);
      push(16'hA002);
      chk("stv_count", 32'(fifoCount), 32'd2);
      ctrlCmd = 2'b10; ctrlData = 16'h5555; ctrlReq = 1'b1;
      expCtrl(2'b10, 16'h5555); expCtrl(2'b10, 16'h5555); expAudio(16'hA001);
      expCtrl(2'b10, 16'h5555); expCtrl(2'b10, 16'h5555); expAudio(16'hA002);
      target = sendCnt + 6;
      autoResp = 1'b1; respLen = 1;
      forceBusy = 1'b0;
      for (int i = 0; i < 200 && sendCnt < target; i++) tick(1);
      ctrlReq = 1'b0;
      chk("stv_sends", 32'(sendCnt), 32'(target));
      chk("stv_queue", 32'(q.size()), 32'd0);
      waitIdle("stv_idle");
      chk("stv_empty", 32'(fifoCount), 32'd0);

      // ---- overflow: six pushes into a four-entry FIFO
      forceBusy = 1'b1;
      for (int i = 1; i <= 6; i++) push(16'(i));
      expDrop += 2;
      chk("ovf_count", 32'(fifoCount), 32'd4);
      chk("ovf_drop", 32'(audioDrop), 32'(expDrop));
      for (int i = 1; i <= 4; i++) expAudio(16'(i));
      forceBusy = 1'b0;
      waitDrain("ovf_drain");
      waitIdle("ovf_idle");
      chk("ovf_empty", 32'(fifoCount), 32'd0);

      // ---- handshake timeout
      autoResp = 1'b0;
      forceBusy = 1'b1;
      push(16'hB001);
      push(16'hB002);
      expAudio(16'hB001); expAudio(16'hB002);
      forceBusy = 1'b0;
      for (int i = 0; i < 20 && !sendFlag; i++) tick(1);
      chk("tmo_send", 32'(sendFlag), 32'd1);
      sawTmo = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick(1);
         sawTmo |= timeoutFlag;
      end
      chk("tmo_early", 32'(sawTmo), 32'd0);
      tick(1);
      chk("tmo_flag", 32'(timeoutFlag), 32'd1);
      chk("tmo_idle", 32'(arbState), 32'd0);
      autoResp = 1'b1;
      tick(1);
      chk("tmo_next", 32'({sendFlag, timeoutFlag}), 32'b10);
      waitDrain("tmo_drain");
      waitIdle("tmo_idle2");

      // ---- push and pop in the same cycle at full
      forceBusy = 1'b1;
      for (int i = 1; i <= 4; i++) push(16'hC000 + 16'(i));
      chk("pp_full", 32'(fifoCount), 32'd4);
      for (int i = 1; i <= 5; i++) expAudio(16'hC000 + 16'(i));
      audioValid = 1'b1; audioIn = 16'hC005;
      forceBusy = 1'b0;
      tick(1);
      audioValid = 1'b0;
      chk("pp_grant", 32'(sendFlag), 32'd1);
      chk("pp_count", 32'(fifoCount), 32'd4);
      chk("pp_drop", 32'(audioDrop), 32'(expDrop));
      waitDrain("pp_drain");
      waitIdle("pp_idle");

      // ---- asynchronous reset in WAIT_BUSY with three samples left
      autoResp = 1'b0;
      forceBusy = 1'b1;
      for (int i = 1; i <= 4; i++) push(16'hD000 + 16'(i));
      forceBusy = 1'b0;
      tick(1);
      chk("ar_state", 32'(arbState), 32'd1);
      chk("ar_count", 32'(fifoCount), 32'd3);
      #1 reset = 1'b1;
      #1;
      chk("ar_send", 32'({sendFlag, ctrlAck, cmd, dataOut}), 32'd0);
      chk("ar_stat", 32'({arbBusy, fifoCount, audioDrop, timeoutFlag, arbState}), 32'd0);
      tick(1);
      reset = 1'b0;
      expDrop = 0;
      tick(8);
      chk("ar_after", 32'({arbState, fifoCount, audioDrop}), 32'd0);
      chk("ar_nosend", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/transport_arbiter.md
# transport_arbiter

Shares the single transport-layer transmit port between the call-control path of the `session` block and its outgoing audio stream. Control messages (call setup, ring, hang-up) are issued ahead of audio, but the number of consecutive control grants is bounded so audio cannot starve. Outgoing audio is buffered in a small FIFO, and a send/acknowledge handshake with timeout runs against `transportBusy`. The block sits between `session` and `transport`.

## Interface
- `FIFO_DEPTH`, default 4: audio FIFO entries; legal range 1..7.
- `CTRL_BURST`, default 2: maximum consecutive control grants while audio is pending; must be ≥1.
- `AUDIO_CMD`, default 2'b11: `cmd` code driven for audio sends.
- `ACK_TIMEOUT`, default 15: cycles allowed for `transportBusy` to rise after a send; must be ≥2.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ctrlReq` in 1: control request (level); held until `ctrlAck`.
- `ctrlCmd` in 2: control command; must be stable while `ctrlReq` is high.
- `ctrlData` in 16: control payload, e.g. {phoneNum, opcode}; must be stable while `ctrlReq` is high.
- `ctrlAck` out 1: one-cycle pulse when the control request is issued.
- `audioValid` in 1: one-cycle strobe that pushes `audioIn`.
- `audioIn` in 16: audio sample.
- `transportBusy` in 1: transport is processing a send.
- `sendFlag` out 1: one-cycle strobe; `cmd`/`dataOut` are valid this cycle.
- `cmd` out 2: command to transport.
- `dataOut` out 16: payload to transport.
- `arbBusy` out 1: high whenever state ≠ IDLE.
- `fifoCount` out 3: audio FIFO occupancy.
- `audioDrop` out 8: count of overflow drops; saturates at 255.
- `timeoutFlag` out 1: one-cycle pulse on handshake timeout.
- `arbState` out 2: state encoding: IDLE=0, WAIT_BUSY=1, WAIT_DONE=2.

## Operation
- Reset values: all outputs are 0, FIFO is empty, `ctrlRun`=0, `timer`=0, state is IDLE. Reset asserted mid-operation aborts any send immediately and discards FIFO contents.
- FIFO behaviour:
  - Push on `audioValid`.
  - Pop occurs only on an audio grant.
  - Full with push and no pop: the sample is dropped and `audioDrop` increments.
  - Full with push and pop in the same cycle: the push is accepted, count is unchanged, no drop.
  - Empty with push only: count becomes 1. Audio cannot be granted in that cycle; the pop happens on a later edge.
  - Wrap-around: read and write pointers are modulo `FIFO_DEPTH`.
- IDLE: arbitration runs only when `transportBusy`=0.
  - Control wins if `ctrlReq` && (FIFO empty || `ctrlRun` < `CTRL_BURST`).
  - Otherwise audio wins if the FIFO is non-empty.
  - Otherwise no grant.
- Control grant:
  - `sendFlag`=1, `ctrlAck`=1, `cmd`=`ctrlCmd`, `dataOut`=`ctrlData`.
  - `ctrlRun` increments (saturating at `CTRL_BURST`) if the FIFO is non-empty; otherwise `ctrlRun` clears.
  - Next state is WAIT_BUSY.
- Audio grant:
  - `sendFlag`=1, `cmd`=`AUDIO_CMD`, `dataOut`=FIFO head, pop, `ctrlRun`=0.
  - Next state is WAIT_BUSY.
- WAIT_BUSY: `timer` starts at 0 and increments each cycle.
  - If `transportBusy`=1, go to WAIT_DONE.
  - Else if `timer`=`ACK_TIMEOUT`−1, pulse `timeoutFlag` and return to IDLE. The send is abandoned and not retried.
- WAIT_DONE: on `transportBusy`=0, return to IDLE.
- `cmd`/`dataOut` hold their last granted value until the next grant.

## Timing
- All outputs are registered.
- A request visible in IDLE at edge N produces `sendFlag`/`ctrlAck` high during cycle N+1.
- Audio latency: push at edge N (FIFO empty, idle) gives `sendFlag` at edge N+1.
- Send spacing: after `transportBusy` falls, IDLE is re-entered on the next edge. The next `sendFlag` can appear one edge after that, so the minimum spacing is 3 cycles with a 1-cycle busy.
- A requester deasserting `ctrlReq` before `ctrlAck` is a protocol violation; behaviour is undefined.

## Test plan
- **Reset:** pulse `reset` mid-WAIT_BUSY with `fifoCount`=3 → all outputs 0, `arbState`=0, `fifoCount`=0 asynchronously.
- **Single control send:** `ctrlReq`=1, `ctrlCmd`=2'b01, `ctrlData`=16'h3001, transport idle.
  - Expect `sendFlag`=`ctrlAck`=1 for exactly one cycle with `cmd`=01, `dataOut`=16'h3001.
  - Bench raises busy for 3 cycles → `arbState` goes 1→2→0.
- **Starvation bound:** preload FIFO with 16'hA001, 16'hA002; hold `ctrlReq`; auto-responding transport.
  - Required grant order: ctrl, ctrl, audio A001, ctrl, ctrl, audio A002.
- **Overflow:** 6 back-to-back `audioValid` with samples 1..6 while `transportBusy`=1.
  - Expect `fifoCount`=4 and `audioDrop`=2.
  - After release, sends carry 1,2,3,4 in order.
- **Timeout:** issue an audio send; `transportBusy` stays 0.
  - Expect `timeoutFlag` pulse 15 cycles after `sendFlag`, then return to IDLE.
  - The next FIFO entry is sent.
- **Simultaneous push/pop at full:** FIFO full, audio grant and `audioValid` in the same cycle → `fifoCount` stays 4, `audioDrop` unchanged.
